// File: rtl/alu_cmdq_pkg.sv
// rtl/alu_cmdq_pkg.sv - register map, bit indices, FSM encoding and entry widths for alu_cmdq
package alu_cmdq_pkg;

  localparam logic [4:0] ADDR_OPA    = 5'h00;
  localparam logic [4:0] ADDR_OPB    = 5'h04;
  localparam logic [4:0] ADDR_Q      = 5'h08;
  localparam logic [4:0] ADDR_R      = 5'h0C;
  localparam logic [4:0] ADDR_FUNC   = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h11;
  localparam logic [4:0] ADDR_CTRL   = 5'h12;
  localparam logic [4:0] ADDR_POP    = 5'h13;
  localparam logic [4:0] ADDR_COUNT  = 5'h14;

  localparam int STAT_CMD_EMPTY = 0;
  localparam int STAT_CMD_FULL  = 1;
  localparam int STAT_RES_EMPTY = 2;
  localparam int STAT_RES_FULL  = 3;
  localparam int STAT_BUSY      = 4;
  localparam int STAT_CMD_OVF   = 5;
  localparam int STAT_RES_UDF   = 6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_FLUSH   = 2;
  localparam int CTRL_CLR_ERR = 3;

  localparam int FUNC_PUSH = 7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Command entry is {func, opa, opb}; result entry is {q, r}.
  function automatic int cmd_width(int dw);
    return 4 + 2 * dw;
  endfunction

  function automatic int res_width(int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/alu_cmdq_sync_fifo.sv
// rtl/alu_cmdq_sync_fifo.sv - show-ahead synchronous FIFO with clear, used for command and result queues
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [3:0]       count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the pre-pop count, so a push never bypasses a same-cycle pop.
  assign full    = (count == 4'(DEPTH));
  assign empty   = (count == 4'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmdq.sv
// rtl/alu_cmdq.sv - queued ALU front end: pi register bus, command/result FIFOs and engine sequencer
module alu_cmdq
  import alu_cmdq_pkg::*;
#(
  parameter int DW        = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pi_blk_sel,
  input  logic [4:0]    pi_addr,
  input  logic          pi_wr_en,
  input  logic          pi_rd_en,
  input  logic [7:0]    pi_wr_data,
  output logic [7:0]    pi_rd_data,
  input  logic          interrupt_ack,
  output logic          interrupt,
  output logic          eng_ce,
  output logic          eng_start,
  output logic [DW-1:0] eng_a,
  output logic [DW-1:0] eng_b,
  output logic [3:0]    eng_op,
  input  logic          eng_valid,
  input  logic [DW-1:0] eng_q,
  input  logic [DW-1:0] eng_r
);

  localparam int NB   = DW / 8;
  localparam int CMDW = cmd_width(DW);
  localparam int RESW = res_width(DW);

  logic            wr, rd;
  logic [DW-1:0]   opa, opb, q_lat, r_lat;
  logic [3:0]      func;
  logic            en, irq_en, cmd_ovf, res_udf, discard, busy;
  logic            flush, clr_err, cmd_push_req, res_pop_req;
  logic            cmd_pop, res_push, irq_set;
  logic [CMDW-1:0] cmd_dout;
  logic [RESW-1:0] res_dout;
  logic            cmd_full, cmd_empty, res_full, res_empty;
  logic [3:0]      cmd_count, res_count;
  logic [7:0]      status, rd_next;
  state_t          state, state_next;

  assign wr           = pi_blk_sel & pi_wr_en;
  assign rd           = pi_blk_sel & pi_rd_en;
  assign flush        = wr && (pi_addr == ADDR_CTRL) && pi_wr_data[CTRL_FLUSH];
  assign clr_err      = wr && (pi_addr == ADDR_CTRL) && pi_wr_data[CTRL_CLR_ERR];
  assign cmd_push_req = wr && (pi_addr == ADDR_FUNC) && pi_wr_data[FUNC_PUSH];
  assign res_pop_req  = wr && (pi_addr == ADDR_POP);
  assign busy         = (state != S_IDLE);
  assign eng_ce       = en;
  assign status       = {1'b0, res_udf, cmd_ovf, busy, res_full, res_empty, cmd_full, cmd_empty};

  sync_fifo #(.WIDTH(CMDW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (cmd_push_req),
    .pop   (cmd_pop),
    .din   ({pi_wr_data[3:0], opa, opb}),
    .dout  (cmd_dout),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(.WIDTH(RESW), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (res_push),
    .pop   (res_pop_req),
    .din   ({q_lat, r_lat}),
    .dout  (res_dout),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  // Issuing only with a free result slot means the WRITE push can never be dropped.
  always_comb begin
    state_next = state;
    cmd_pop    = 1'b0;
    eng_start  = 1'b0;
    res_push   = 1'b0;
    irq_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && !cmd_empty && !res_full) begin
          cmd_pop    = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (eng_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (!discard && !flush) begin
          res_push = 1'b1;
          irq_set  = irq_en;
        end
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      eng_a   <= '0;
      eng_b   <= '0;
      eng_op  <= 4'd0;
      q_lat   <= '0;
      r_lat   <= '0;
      discard <= 1'b0;
    end else begin
      state <= state_next;
      if (cmd_pop) {eng_op, eng_a, eng_b} <= cmd_dout;
      if (state == S_WAIT && eng_valid) begin
        q_lat <= eng_q;
        r_lat <= eng_r;
      end
      // A flush that races the issuing pop still has to kill that command's result.
      if (flush && (state == S_ISSUE || state == S_WAIT || cmd_pop)) discard <= 1'b1;
      else if (state == S_WRITE) discard <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      func    <= 4'd0;
      en      <= 1'b0;
      irq_en  <= 1'b0;
      cmd_ovf <= 1'b0;
      res_udf <= 1'b0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wr && pi_addr == ADDR_OPA + 5'(k)) opa[8*k +: 8] <= pi_wr_data;
        if (wr && pi_addr == ADDR_OPB + 5'(k)) opb[8*k +: 8] <= pi_wr_data;
      end
      if (wr && pi_addr == ADDR_FUNC) func <= pi_wr_data[3:0];
      if (wr && pi_addr == ADDR_CTRL) begin
        en     <= pi_wr_data[CTRL_EN];
        irq_en <= pi_wr_data[CTRL_IRQ_EN];
      end
      if (clr_err) begin
        cmd_ovf <= 1'b0;
        res_udf <= 1'b0;
      end else begin
        if (cmd_push_req && cmd_full)  cmd_ovf <= 1'b1;
        if (res_pop_req && res_empty)  res_udf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                interrupt <= 1'b0;
    else if (irq_set)       interrupt <= 1'b1;
    else if (interrupt_ack) interrupt <= 1'b0;
  end

  always_comb begin
    rd_next = 8'h00;
    for (int k = 0; k < NB; k++) begin
      if (pi_addr == ADDR_OPA + 5'(k)) rd_next = opa[8*k +: 8];
      if (pi_addr == ADDR_OPB + 5'(k)) rd_next = opb[8*k +: 8];
      if (pi_addr == ADDR_Q + 5'(k) && !res_empty) rd_next = res_dout[DW + 8*k +: 8];
      if (pi_addr == ADDR_R + 5'(k) && !res_empty) rd_next = res_dout[8*k +: 8];
    end
    case (pi_addr)
      ADDR_FUNC:   rd_next = {4'd0, func};
      ADDR_STATUS: rd_next = status;
      ADDR_CTRL:   rd_next = {6'd0, irq_en, en};
      ADDR_COUNT:  rd_next = {res_count, cmd_count};
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pi_rd_data <= 8'h00;
    else     pi_rd_data <= rd ? rd_next : 8'h00;
  end

endmodule

// File: tb/tb_alu_cmdq.sv
// tb/tb_alu_cmdq.sv - directed self-checking bench for alu_cmdq at DW=32 and DW=16
module tb_alu_cmdq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel32 = 1'b0, sel16 = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [4:0] addr = 5'd0;
  logic [7:0] wdata = 8'd0;
  logic ack32 = 1'b0, ack16 = 1'b0;

  logic [7:0]  rd32, rd16;
  logic        irq32, irq16, ce32, ce16, st32, st16;
  logic [31:0] a32, b32;
  logic [15:0] a16, b16;
  logic [3:0]  op32, op16;
  logic        valid32 = 1'b0, valid16 = 1'b0;
  logic [31:0] q32 = '0, r32 = '0, ea32 = '0, eb32 = '0;
  logic [15:0] q16 = '0, r16 = '0, ea16 = '0, eb16 = '0;
  logic [1:0]  cnt32 = 2'd0, cnt16 = 2'd0;

  int checks = 0;
  int errors = 0;
  int starts32 = 0;
  int s0, n0;
  logic [31:0] cap_a[$];
  logic [31:0] cap_b[$];
  logic [3:0]  cap_op[$];
  logic [7:0]  b;
  logic [31:0] w;

  always #5 clk = ~clk;

  alu_cmdq #(.DW(32), .CMD_DEPTH(4), .RES_DEPTH(4)) u32 (
    .clk(clk), .rst(rst), .pi_blk_sel(sel32), .pi_addr(addr), .pi_wr_en(wr_en),
    .pi_rd_en(rd_en), .pi_wr_data(wdata), .pi_rd_data(rd32), .interrupt_ack(ack32),
    .interrupt(irq32), .eng_ce(ce32), .eng_start(st32), .eng_a(a32), .eng_b(b32),
    .eng_op(op32), .eng_valid(valid32), .eng_q(q32), .eng_r(r32)
  );

  alu_cmdq #(.DW(16), .CMD_DEPTH(4), .RES_DEPTH(4)) u16 (
    .clk(clk), .rst(rst), .pi_blk_sel(sel16), .pi_addr(addr), .pi_wr_en(wr_en),
    .pi_rd_en(rd_en), .pi_wr_data(wdata), .pi_rd_data(rd16), .interrupt_ack(ack16),
    .interrupt(irq16), .eng_ce(ce16), .eng_start(st16), .eng_a(a16), .eng_b(b16),
    .eng_op(op16), .eng_valid(valid16), .eng_q(q16), .eng_r(r16)
  );

  // Engine model: q=a+b, r=a-b, eng_valid 3 cycles after start, frozen while eng_ce=0.
  always @(posedge clk) begin
    valid32 <= 1'b0;
    if (rst) cnt32 <= 2'd0;
    else if (st32) begin cnt32 <= 2'd2; ea32 <= a32; eb32 <= b32; end
    else if (ce32 && cnt32 != 2'd0) begin
      cnt32 <= cnt32 - 2'd1;
      if (cnt32 == 2'd1) begin valid32 <= 1'b1; q32 <= ea32 + eb32; r32 <= ea32 - eb32; end
    end
  end

  always @(posedge clk) begin
    valid16 <= 1'b0;
    if (rst) cnt16 <= 2'd0;
    else if (st16) begin cnt16 <= 2'd2; ea16 <= a16; eb16 <= b16; end
    else if (ce16 && cnt16 != 2'd0) begin
      cnt16 <= cnt16 - 2'd1;
      if (cnt16 == 2'd1) begin valid16 <= 1'b1; q16 <= ea16 + eb16; r16 <= ea16 - eb16; end
    end
  end

  always @(posedge clk) begin
    if (st32) begin
      starts32 <= starts32 + 1;
      cap_a.push_back(a32);
      cap_b.push_back(b32);
      cap_op.push_back(op32);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input bit i16, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    sel32 = !i16; sel16 = i16; wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel32 = 1'b0; sel16 = 1'b0; wr_en = 1'b0;
  endtask

  task automatic rd(input bit i16, input logic [4:0] a, output logic [7:0] d);
    @(negedge clk);
    sel32 = !i16; sel16 = i16; rd_en = 1'b1; addr = a;
    @(negedge clk);
    d = i16 ? rd16 : rd32;
    sel32 = 1'b0; sel16 = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr_word(input bit i16, input logic [4:0] base, input logic [31:0] v);
    for (int k = 0; k < 4; k++) wr(i16, base + 5'(k), v[8*k +: 8]);
  endtask

  task automatic rd_word(input bit i16, input logic [4:0] base, output logic [31:0] v);
    logic [7:0] t;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      rd(i16, base + 5'(k), t);
      v[8*k +: 8] = t;
    end
  endtask

  task automatic pulse_ack32();
    @(negedge clk); ack32 = 1'b1;
    @(negedge clk); ack32 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(3); rst = 1'b0;
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h05) begin errors++; $display("FAIL reset_status got %h want 05", b); end
    idle(1);
    checks++; if (rd32 !== 8'h00) begin errors++; $display("FAIL rd_data_idle got %h want 00", rd32); end
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", b); end
    rd(0, 5'h12, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", b); end
    checks++; if ({irq32, st32, a32, op32} !== 37'd0) begin errors++; $display("FAIL reset_outputs got irq=%b start=%b a=%h op=%h want 0", irq32, st32, a32, op32); end
  endtask

  task automatic test_single_op();
    wr_word(0, 5'h00, 32'h10);
    wr_word(0, 5'h04, 32'h3);
    wr(0, 5'h12, 8'h03);
    s0 = starts32;
    wr(0, 5'h10, 8'h81);
    idle(20);
    checks++; if (starts32 - s0 !== 1) begin errors++; $display("FAIL single_starts got %0d want 1", starts32 - s0); end
    checks++; if ({cap_a[$], cap_b[$], cap_op[$]} !== {32'h10, 32'h3, 4'h1}) begin errors++; $display("FAIL single_issue got a=%h b=%h op=%h want 10 3 1", cap_a[$], cap_b[$], cap_op[$]); end
    checks++; if (irq32 !== 1'b1) begin errors++; $display("FAIL single_irq got %b want 1", irq32); end
    rd_word(0, 5'h08, w);
    checks++; if (w !== 32'h13) begin errors++; $display("FAIL single_q got %h want 00000013", w); end
    rd_word(0, 5'h0C, w);
    checks++; if (w !== 32'h0D) begin errors++; $display("FAIL single_r got %h want 0000000d", w); end
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h01) begin errors++; $display("FAIL single_status got %h want 01", b); end
    checks++; if (irq32 !== 1'b1) begin errors++; $display("FAIL single_irq_held got %b want 1", irq32); end
    pulse_ack32();
    checks++; if (irq32 !== 1'b0) begin errors++; $display("FAIL single_irq_ack got %b want 0", irq32); end
    wr(0, 5'h13, 8'h00);
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h05) begin errors++; $display("FAIL single_pop_status got %h want 05", b); end
    rd_word(0, 5'h00, w);
    checks++; if (w !== 32'h10) begin errors++; $display("FAIL single_opa_rb got %h want 00000010", w); end
  endtask

  task automatic test_queue_full();
    wr(0, 5'h12, 8'h02);
    s0 = starts32; n0 = cap_op.size();
    for (int i = 0; i < 5; i++) begin
      wr_word(0, 5'h00, 32'(32'h20 + i));
      wr_word(0, 5'h04, 32'(i));
      wr(0, 5'h10, 8'(8'h80 | i));
    end
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h04) begin errors++; $display("FAIL qfull_count got %h want 04", b); end
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h26) begin errors++; $display("FAIL qfull_status got %h want 26", b); end
    checks++; if (starts32 != s0) begin errors++; $display("FAIL qfull_no_issue got %0d want 0", starts32 - s0); end
    wr(0, 5'h12, 8'h03);
    idle(60);
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h40) begin errors++; $display("FAIL qfull_done_count got %h want 40", b); end
    checks++; if (starts32 - s0 != 4) begin errors++; $display("FAIL qfull_starts got %0d want 4", starts32 - s0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_op[n0 + i] !== 4'(i)) begin errors++; $display("FAIL qfull_order%0d got %h want %h", i, cap_op[n0 + i], i); end
      rd_word(0, 5'h08, w);
      checks++; if (w !== 32'(32'h20 + 2 * i)) begin errors++; $display("FAIL qfull_q%0d got %h want %h", i, w, 32'h20 + 2 * i); end
      rd_word(0, 5'h0C, w);
      checks++; if (w !== 32'h20) begin errors++; $display("FAIL qfull_r%0d got %h want 00000020", i, w); end
      wr(0, 5'h13, 8'h00);
    end
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h25) begin errors++; $display("FAIL qfull_ovf_sticky got %h want 25", b); end
    wr(0, 5'h12, 8'h0B);
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h05) begin errors++; $display("FAIL qfull_clr_err got %h want 05", b); end
    pulse_ack32();
  endtask

  task automatic test_backpressure();
    wr_word(0, 5'h00, 32'h100);
    wr_word(0, 5'h04, 32'h1);
    s0 = starts32;
    for (int i = 0; i < 6; i++) begin
      wr(0, 5'h10, 8'h82);
      idle(12);
    end
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h42) begin errors++; $display("FAIL bp_count got %h want 42", b); end
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h08) begin errors++; $display("FAIL bp_status got %h want 08", b); end
    checks++; if (starts32 - s0 != 4) begin errors++; $display("FAIL bp_starts got %0d want 4", starts32 - s0); end
    rd_word(0, 5'h08, w);
    checks++; if (w !== 32'h101) begin errors++; $display("FAIL bp_q got %h want 00000101", w); end
    wr(0, 5'h13, 8'h00);
    idle(20);
    checks++; if (starts32 - s0 != 5) begin errors++; $display("FAIL bp_resume got %0d want 5", starts32 - s0); end
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h41) begin errors++; $display("FAIL bp_resume_count got %h want 41", b); end
    wr(0, 5'h12, 8'h07);
    idle(2);
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL flush_count got %h want 00", b); end
    rd(0, 5'h12, b);
    checks++; if (b !== 8'h03) begin errors++; $display("FAIL flush_ctrl got %h want 03", b); end
    rd_word(0, 5'h00, w);
    checks++; if (w !== 32'h100) begin errors++; $display("FAIL flush_keeps_opa got %h want 00000100", w); end
    pulse_ack32();
  endtask

  task automatic test_flush_midop();
    wr_word(0, 5'h00, 32'h5);
    wr_word(0, 5'h04, 32'h2);
    s0 = starts32;
    wr(0, 5'h10, 8'h81);
    wr(0, 5'h10, 8'h81);
    wr(0, 5'h12, 8'h07);
    idle(20);
    checks++; if (starts32 - s0 != 1) begin errors++; $display("FAIL fmid_starts got %0d want 1", starts32 - s0); end
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL fmid_count got %h want 00", b); end
    checks++; if (irq32 !== 1'b0) begin errors++; $display("FAIL fmid_irq got %b want 0", irq32); end
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h05) begin errors++; $display("FAIL fmid_status got %h want 05", b); end
    wr(0, 5'h10, 8'h81);
    idle(20);
    checks++; if (irq32 !== 1'b1) begin errors++; $display("FAIL fmid_next_irq got %b want 1", irq32); end
    rd_word(0, 5'h08, w);
    checks++; if (w !== 32'h7) begin errors++; $display("FAIL fmid_next_q got %h want 00000007", w); end
    wr(0, 5'h13, 8'h00);
    pulse_ack32();
  endtask

  task automatic test_underflow();
    wr(0, 5'h13, 8'h00);
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h45) begin errors++; $display("FAIL udf_set got %h want 45", b); end
    wr(0, 5'h12, 8'h0B);
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h05) begin errors++; $display("FAIL udf_clear got %h want 05", b); end
    wr(0, 5'h10, 8'h81);
    idle(20);
    wr_word(0, 5'h00, 32'h30);
    wr(0, 5'h10, 8'h81);
    idle(4);
    wr(0, 5'h13, 8'h00);
    idle(2);
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h10) begin errors++; $display("FAIL simul_count got %h want 10", b); end
    rd_word(0, 5'h08, w);
    checks++; if (w !== 32'h32) begin errors++; $display("FAIL simul_q got %h want 00000032", w); end
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h01) begin errors++; $display("FAIL simul_status got %h want 01", b); end
    wr(0, 5'h13, 8'h00);
    pulse_ack32();
  endtask

  task automatic test_reset_midop();
    wr(0, 5'h10, 8'h81);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (a32 !== 32'h0) begin errors++; $display("FAIL rmid_eng_a got %h want 0", a32); end
    rd(0, 5'h11, b);
    checks++; if (b !== 8'h05) begin errors++; $display("FAIL rmid_status got %h want 05", b); end
    rd(0, 5'h12, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL rmid_ctrl got %h want 00", b); end
    idle(10);
    rd(0, 5'h14, b);
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL rmid_count got %h want 00", b); end
  endtask

  task automatic test_dw16();
    wr(1, 5'h12, 8'h03);
    wr_word(1, 5'h00, 32'hAABBFFFF);
    rd_word(1, 5'h00, w);
    checks++; if (w !== 32'h0000FFFF) begin errors++; $display("FAIL dw16_opa got %h want 0000ffff", w); end
    wr_word(1, 5'h04, 32'h1);
    wr(1, 5'h10, 8'h81);
    idle(20);
    checks++; if (a16 !== 16'hFFFF) begin errors++; $display("FAIL dw16_eng_a got %h want ffff", a16); end
    rd(1, 5'h11, b);
    checks++; if (b !== 8'h01) begin errors++; $display("FAIL dw16_status got %h want 01", b); end
    rd_word(1, 5'h08, w);
    checks++; if (w !== 32'h0) begin errors++; $display("FAIL dw16_q got %h want 00000000", w); end
    rd_word(1, 5'h0C, w);
    checks++; if (w !== 32'h0000FFFE) begin errors++; $display("FAIL dw16_r got %h want 0000fffe", w); end
    checks++; if (irq16 !== 1'b1) begin errors++; $display("FAIL dw16_irq got %b want 1", irq16); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_op();
    test_queue_full();
    test_backpressure();
    test_flush_midop();
    test_underflow();
    test_reset_midop();
    test_dw16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
